mem_access_unit: RTL and testbench

- Parametrised successor of the pipeline MEM stage.
- Replaces the single-cycle memory/bridge access with a request/acknowledge bus handshake that can take several cycles, and stalls the pipeline while the access is pending.
- Generates byte enables, aligns and extends load data, checks alignment and address range, and merges its own AdEL/AdES exceptions with those arriving from earlier stages.
- Sits between the EX/MEM and MEM/WB pipeline registers; drives the bridge bus.

---
 rtl/mem_access_unit.sv | 116 +++++++++++
 tb/tb_mem_access_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage with req/ack bus handshake, byte lanes, load extension and AdEL/AdES checks.
// Optional MEM_TIMEOUT_EN: fault an access that sees no ack/err within TIMEOUT REQ cycles.
module mem_access_unit #(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_7f2f,
  parameter int          TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [1:0]          op_in,
  input  logic [1:0]          size_in,
  input  logic                sign_in,
  input  logic [31:0]         addr_in,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic                exception_in,
  input  logic [4:0]          exc_code_in,
  output logic                bus_req,
  output logic                bus_we,
  output logic [31:0]         bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall,
  output logic [DATA_W-1:0]   mo,
  output logic                exception_out,
  output logic [4:0]          exc_code_out
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [OFF_W-1:0] off, off_q;
  logic [3:0] nbytes;
  logic [32:0] last;
  logic mem_op, mis, oor, fault, start, tmo, err, fin;
  logic [BE_W-1:0] be_d;
  logic [1:0] size_q;
  logic sign_q, err_q;
  logic [4:0] code_q;
  logic [6:0] nbits;
  logic [DATA_W-1:0] sh, mask, ext;
  logic sbit;
  assign mem_op = op_in == 2'd1 || op_in == 2'd2;
  assign off    = addr_in[OFF_W-1:0];
  assign nbytes = 4'd1 << size_in;
  assign mis    = (addr_in[3:0] & (nbytes - 4'd1)) != 4'd0 || (DATA_W == 32 && size_in == 2'd3);
  assign last   = {1'b0, addr_in} + 33'(nbytes) - 33'd1;
  assign oor    = addr_in < ADDR_LO || last > {1'b0, ADDR_HI};
  assign fault  = valid_in & mem_op & ~exception_in & (mis | oor);
  assign start  = state == IDLE & valid_in & mem_op & ~exception_in & ~fault;
  assign be_d   = BE_W'((16'd1 << nbytes) - 16'd1) << off;
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || state != REQ) cnt <= '0;
    else cnt <= cnt + CNT_W'(1);
  assign tmo = state == REQ && cnt == CNT_W'(TIMEOUT - 1) && !bus_ack;
`else
  assign tmo = TIMEOUT < 0;
`endif
  assign err = bus_err | tmo;
  assign fin = state == REQ & (bus_ack | err);
  // load lanes: shift the addressed byte down, keep size bytes, then extend
  assign sh    = bus_rdata >> {off_q, 3'b000};
  assign nbits = 7'd8 << size_q;
  assign mask  = size_q == 2'd3 ? '1 : (DATA_W'(1) << nbits) - DATA_W'(1);
  assign sbit  = sign_q & |((sh >> (nbits - 7'd1)) & DATA_W'(1));
  assign ext   = (sh & mask) | (sbit ? ~mask : '0);
  always_comb begin
    state_nx      = state == IDLE ? (start ? REQ : IDLE) : state == REQ ? (fin ? DONE : REQ) : IDLE;
    stall         = start | state == REQ;
    exception_out = state == DONE ? err_q : state == REQ ? 1'b0 : exception_in | fault;
    exc_code_out  = state == DONE ? (err_q ? code_q : 5'd0) : state == REQ ? 5'd0 :
                    fault ? (op_in == 2'd2 ? 5'd5 : 5'd4) : exc_code_in;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      mo        <= '0;
      off_q     <= '0;
      size_q    <= '0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= op_in == 2'd2;
        bus_addr  <= addr_in & ~32'(BE_W - 1);
        bus_be    <= be_d;
        bus_wdata <= wdata_in << {off, 3'b000};
        off_q     <= off;
        size_q    <= size_in;
        sign_q    <= sign_in;
      end
      if (fin) begin
        bus_req <= 1'b0;
        bus_we  <= 1'b0;
        bus_be  <= '0;
        err_q   <= err;
        code_q  <= bus_we ? 5'd5 : 5'd4;
        if (!err && !bus_we) mo <= ext;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plan cases plus randomized accesses checked against a behavioural model.
module tb_mem_access_unit;
  localparam logic [31:0] LO = 32'h0000_0000;
  localparam logic [31:0] HI = 32'h0000_7f2f;
  logic clk = 1'b0;
  logic reset, valid_in, sign_in, exception_in, bus_ack, bus_err;
  logic [1:0] op_in, size_in;
  logic [31:0] addr_in, wdata_in, bus_rdata, bus_addr, bus_wdata, mo;
  logic [4:0] exc_code_in, exc_code_out;
  logic bus_req, bus_we, stall, exception_out;
  logic [3:0] bus_be;
  logic [31:0] mo_m;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.DATA_W(32), .ADDR_LO(LO), .ADDR_HI(HI), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op_in(op_in), .size_in(size_in),
    .sign_in(sign_in), .addr_in(addr_in), .wdata_in(wdata_in), .exception_in(exception_in),
    .exc_code_in(exc_code_in), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata), .stall(stall), .mo(mo), .exception_out(exception_out),
    .exc_code_out(exc_code_out));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] size, input logic sg);
    longint v, nbits;
    nbits = 8 * (1 << size);
    v = longint'((64'(rd) >> (8 * (a % 4))) & ((64'd1 << nbits) - 1));
    if (sg && v >= longint'(64'd1 << (nbits - 1))) v = v - longint'(64'd1 << nbits);
    return v[31:0];
  endfunction
  task automatic run(input logic v, input logic [1:0] op, input logic [1:0] size, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic ei,
                     input logic [4:0] ec, input int lat, input logic ack, input logic err,
                     input logic [31:0] rd);
    logic [31:0] nb, be, m;
    logic mis, oor, flt, st;
    longint last;
    @(negedge clk);
    valid_in = v; op_in = op; size_in = size; sign_in = sg; addr_in = a; wdata_in = wd;
    exception_in = ei; exc_code_in = ec; bus_ack = 1'b0; bus_err = 1'b0;
    nb   = 32'd1 << size;
    mis  = (a % nb) != 0 || size == 2'd3;
    last = longint'(a) + longint'(nb) - 1;
    oor  = a < LO || last > longint'(HI);
    flt  = v && (op == 2'd1 || op == 2'd2) && !ei && (mis || oor);
    st   = v && (op == 2'd1 || op == 2'd2) && !ei && !flt;
    #1;
    check("stall_issue", stall, st);
    check("req_issue", bus_req, 0);
    check("exc_issue", exception_out, ei | flt);
    check("code_issue", exc_code_out, ei ? ec : flt ? (op == 2'd2 ? 5'd5 : 5'd4) : ec);
    check("mo_hold", mo, mo_m);
    if (st) begin
      @(negedge clk); #1;
      be = ((32'd1 << nb) - 1) << (a % 4);
      m = 0;
      for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hff << (8 * i));
      check("req", bus_req, 1);
      check("stall_req", stall, 1);
      check("we", bus_we, op == 2'd2);
      check("addr", bus_addr, a & ~32'h3);
      check("be", bus_be, be);
      check("wdata", bus_wdata & m, (wd << (8 * (a % 4))) & m);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk); #1;
        check("stall_wait", stall, 1);
        check("req_wait", bus_req, 1);
      end
      bus_ack = ack; bus_err = err; bus_rdata = rd;
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0;
      #1;
      if (!err && op == 2'd1) mo_m = load_val(rd, a, size, sg);
      check("stall_done", stall, 0);
      check("req_done", bus_req, 0);
      check("exc_done", exception_out, err);
      check("code_done", exc_code_out, err ? (op == 2'd2 ? 5'd5 : 5'd4) : 5'd0);
      check("mo_done", mo, mo_m);
    end
  endtask
  initial begin
    logic [31:0] a;
    int k;
    reset = 1'b1; valid_in = 0; op_in = 0; size_in = 0; sign_in = 0; addr_in = 0; wdata_in = 0;
    exception_in = 0; exc_code_in = 0; bus_ack = 0; bus_err = 0; bus_rdata = 0; mo_m = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_be", bus_be, 0);
    check("rst_mo", mo, 0);
    check("rst_stall", stall, 0);
    check("rst_exc", exception_out, 0);
    check("rst_code", exc_code_out, 0);
    run(1, 2'd1, 2'd2, 0, 32'h100, 0, 0, 0, 1, 1, 0, 32'hdeadbeef);
    check("plan_word", mo, 32'hdeadbeef);
    run(1, 2'd1, 2'd0, 1, 32'h103, 0, 0, 0, 0, 1, 0, 32'h8000_0000);
    check("plan_sbyte", mo, 32'hffff_ff80);
    run(1, 2'd1, 2'd0, 0, 32'h103, 0, 0, 0, 0, 1, 0, 32'h8000_0000);
    check("plan_ubyte", mo, 32'h0000_0080);
    run(1, 2'd2, 2'd1, 0, 32'h102, 32'h1234, 0, 0, 2, 1, 0, 0);
    run(1, 2'd2, 2'd2, 0, 32'h102, 32'h55, 0, 0, 0, 1, 0, 0);
    run(1, 2'd1, 2'd2, 0, 32'h8000, 0, 0, 0, 0, 1, 0, 0);
    run(1, 2'd1, 2'd2, 0, 32'h7f2c, 0, 0, 0, 0, 1, 0, 32'h0bad_f00d);
    run(1, 2'd1, 2'd1, 0, 32'h7f2e, 0, 0, 0, 0, 1, 0, 0);
    run(1, 2'd1, 2'd2, 0, 32'h100, 0, 1, 5'd10, 0, 1, 0, 0);
    run(1, 2'd1, 2'd2, 0, 32'h104, 0, 0, 0, 1, 1, 1, 32'h1111_2222);
    run(1, 2'd1, 2'd2, 0, 32'h200, 0, 0, 0, 0, 1, 0, 0);
    // abort an access mid-REQ; a late ack must not resurrect it
    @(negedge clk);
    valid_in = 1; op_in = 2'd1; size_in = 2'd2; addr_in = 32'h300; exception_in = 0;
    @(negedge clk); #1;
    check("abort_req", bus_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; valid_in = 0; bus_ack = 1'b1; bus_rdata = 32'hffff_ffff; mo_m = 0;
    #1;
    check("abort_req_low", bus_req, 0);
    check("abort_stall", stall, 0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("abort_idle", stall, 0);
    check("abort_mo", mo, 0);
`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    valid_in = 1; op_in = 2'd1; size_in = 2'd2; addr_in = 32'h400; exception_in = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("tmo_wait", stall, 1);
    end
    @(negedge clk); #1;
    check("tmo_exc", exception_out, 1);
    check("tmo_code", exc_code_out, 5'd4);
    check("tmo_req", bus_req, 0);
`endif
    for (int n = 0; n < 300; n++) begin
      k = int'($urandom % 8);
      a = k < 4 ? ($urandom_range(0, 32'h7f40) & ~32'h3) : k < 6 ? $urandom_range(0, 32'h7f40) :
          k == 6 ? 32'h7f28 + ($urandom % 16) : $urandom;
      k = int'($urandom % 4);
      run(($urandom % 8) != 0, 2'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
          ($urandom % 8) == 0, 5'($urandom), int'($urandom % 3), k != 1, k == 1 || k == 3,
          $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
